// File: rtl/subtrator_multiciclo_if.sv
// subtrator_multiciclo_if: start/operand request and registered result bundle of the multicycle subtractor
interface subtrator_multiciclo_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic Bin;
  logic busy;
  logic done;
  logic [WIDTH-1:0] D;
  logic Bout;
  logic B_msb;
  logic zero;
  logic overflow;
  modport master (output start, A, B, Bin, input busy, done, D, Bout, B_msb, zero, overflow);
  modport slave (input start, A, B, Bin, output busy, done, D, Bout, B_msb, zero, overflow);
endinterface

// File: rtl/subtrator_multiciclo.sv
// subtrator_multiciclo: A - B - Bin computed CHUNK bits per clock with a registered running borrow
module subtrator_multiciclo #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input logic clk,
  input logic rst_n,
  subtrator_multiciclo_if.slave bus
);
  localparam int N = WIDTH / CHUNK;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, d_acc, d_full, d_r;
  logic [IW-1:0] idx;
  logic borrow, bout_r, bmsb_r, zero_r, ovf_r;
  logic [CHUNK-1:0] ca, cb, diff;
  logic [CHUNK:0] c;
  logic accept, last;
  always_comb begin
    accept = bus.start && state != RUN;
    last = idx == IW'(N - 1);
    state_nx = accept ? RUN : (state == RUN && last) ? DONE : state == DONE ? IDLE : state;
  end
  // The MSB always sits at local bit CHUNK-1 of the final chunk, so c[CHUNK-1] there is the borrow into it
  always_comb begin
    ca = a_r[idx*CHUNK +: CHUNK];
    cb = b_r[idx*CHUNK +: CHUNK];
    c = '0;
    diff = '0;
    c[0] = borrow;
    for (int i = 0; i < CHUNK; i++) begin
      diff[i] = ca[i] ^ cb[i] ^ c[i];
      c[i+1] = (~ca[i] & cb[i]) | (~(ca[i] ^ cb[i]) & c[i]);
    end
    d_full = d_acc;
    d_full[idx*CHUNK +: CHUNK] = diff;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      borrow <= 1'b0;
      idx <= '0;
      d_acc <= '0;
      d_r <= '0;
      bout_r <= 1'b0;
      bmsb_r <= 1'b0;
      zero_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (accept) begin
      a_r <= bus.A;
      b_r <= bus.B;
      borrow <= bus.Bin;
      idx <= '0;
    end else if (state == RUN) begin
      d_acc <= d_full;
      borrow <= c[CHUNK];
      idx <= idx + 1'b1;
      if (last) begin
        d_r <= d_full;
        bout_r <= c[CHUNK];
        bmsb_r <= c[CHUNK-1];
        zero_r <= d_full == '0;
        ovf_r <= c[CHUNK-1] ^ c[CHUNK];
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.D = d_r;
  assign bus.Bout = bout_r;
  assign bus.B_msb = bmsb_r;
  assign bus.zero = zero_r;
  assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_subtrator_multiciclo.sv
// tb_subtrator_multiciclo: directed checks of the 8/2 and 16/4 multicycle subtractor configurations
module tb_subtrator_multiciclo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  logic seen_done;
  subtrator_multiciclo_if #(.WIDTH(8)) i8 ();
  subtrator_multiciclo_if #(.WIDTH(16)) i16 ();
  subtrator_multiciclo #(.WIDTH(8), .CHUNK(2)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  subtrator_multiciclo #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic res8(input string tag, input logic [7:0] d, input logic bo, input logic bm, input logic z, input logic ov);
    chk({tag, ".D"}, 32'(i8.D), 32'(d));
    chk({tag, ".Bout"}, 32'(i8.Bout), 32'(bo));
    chk({tag, ".B_msb"}, 32'(i8.B_msb), 32'(bm));
    chk({tag, ".zero"}, 32'(i8.zero), 32'(z));
    chk({tag, ".overflow"}, 32'(i8.overflow), 32'(ov));
  endtask
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin);
    i8.A = a;
    i8.B = b;
    i8.Bin = bin;
    i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    chk({tag, ".busy_k"}, 32'(i8.busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, ".done_early"}, 32'(i8.done), 32'd0);
    end
    tick();
    chk({tag, ".done_k4"}, 32'(i8.done), 32'd1);
    chk({tag, ".busy_k4"}, 32'(i8.busy), 32'd0);
  endtask
  initial begin
    i8.start = 1'b0; i8.A = '0; i8.B = '0; i8.Bin = 1'b0;
    i16.start = 1'b0; i16.A = '0; i16.B = '0; i16.Bin = 1'b0;
    tick();
    chk("rst.busy", 32'(i8.busy), 32'd0);
    chk("rst.done", 32'(i8.done), 32'd0);
    res8("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    op8("t5m3", 8'h05, 8'h03, 1'b0);
    res8("t5m3", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pulse.done", 32'(i8.done), 32'd0);
    chk("hold.D", 32'(i8.D), 32'h02);
    op8("t0m1", 8'h00, 8'h01, 1'b0);
    res8("t0m1", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    op8("t80m1", 8'h80, 8'h01, 1'b0);
    res8("t80m1", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    op8("tzero", 8'h10, 8'h0F, 1'b1);
    res8("tzero", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    i8.A = 8'h05; i8.B = 8'h03; i8.Bin = 1'b0; i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    tick();
    tick();
    i8.A = 8'hAA; i8.B = 8'h11; i8.Bin = 1'b1; i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    chk("ign.busy", 32'(i8.busy), 32'd1);
    tick();
    chk("ign.done", 32'(i8.done), 32'd1);
    res8("ign", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    op8("b2b", 8'h20, 8'h30, 1'b0);
    res8("b2b", 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    i8.A = 8'hFF; i8.B = 8'h00; i8.Bin = 1'b0; i8.start = 1'b1;
    tick();
    i8.start = 1'b0;
    chk("b2b.run_D", 32'(i8.D), 32'hF0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(i8.busy), 32'd0);
    chk("arst.done", 32'(i8.done), 32'd0);
    res8("arst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen_done = seen_done | i8.done;
    end
    chk("arst.no_done", 32'(seen_done), 32'd0);
    chk("arst.no_result", 32'(i8.D), 32'h00);
    op8("post", 8'h05, 8'h03, 1'b0);
    res8("post", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    i16.A = 16'h1234; i16.B = 16'h4321; i16.Bin = 1'b0; i16.start = 1'b1;
    tick();
    i16.start = 1'b0;
    chk("w16.busy", 32'(i16.busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("w16.done_early", 32'(i16.done), 32'd0);
    end
    tick();
    chk("w16.done", 32'(i16.done), 32'd1);
    chk("w16.D", 32'(i16.D), 32'hCF13);
    chk("w16.Bout", 32'(i16.Bout), 32'd1);
    chk("w16.B_msb", 32'(i16.B_msb), 32'd1);
    chk("w16.overflow", 32'(i16.overflow), 32'd0);
    chk("w16.zero", 32'(i16.zero), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
